// File: rtl/blink_pkg.sv
// Shared constants for the LED blink generator and the blink-rate decoder:
// half-period lengths, rate-code encodings and the decoder FSM states.
package blink_pkg;

    localparam int unsigned CNT_W       = 16;
    localparam int unsigned CNT_100HZ   = 125;
    localparam int unsigned CNT_50HZ    = 250;
    localparam int unsigned CNT_10HZ    = 1250;
    localparam int unsigned CNT_1HZ     = 12500;
    localparam int unsigned LOCK_COUNT  = 4;
    localparam int unsigned TIMEOUT_CNT = 25000;

    typedef enum logic [1:0] {
        RATE_100HZ = 2'b00,
        RATE_50HZ  = 2'b01,
        RATE_10HZ  = 2'b10,
        RATE_1HZ   = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MEASURE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_e;

    // True when val lies within +/- nominal/8 of the nominal half-period.
    function automatic logic in_window(input logic [CNT_W-1:0] val, input int unsigned nominal);
        int unsigned tol;
        tol = nominal / 32'd8;
        return (32'(val) >= (nominal - tol)) && (32'(val) <= (nominal + tol));
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus edge-detect flop; o_edge strobes for one cycle
// on either polarity of transition of the asynchronous input.
module sync_edge_detect (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_edge
);

    // [0],[1] synchronize; [2] holds the previous synchronized level
    logic [2:0] r_sync;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_edge = r_sync[2] ^ r_sync[1];

endmodule

// File: rtl/blink_rate_decoder.sv
// Measures the half-period of a blinking waveform, classifies it into one of
// four rates and reports a rate code once enough consecutive periods agree.
module blink_rate_decoder
    import blink_pkg::*;
#(
    parameter int unsigned c_CNT_100Hz  = CNT_100HZ,
    parameter int unsigned c_CNT_50Hz   = CNT_50HZ,
    parameter int unsigned c_CNT_10Hz   = CNT_10HZ,
    parameter int unsigned c_CNT_1Hz    = CNT_1HZ,
    parameter int unsigned c_LOCK_COUNT = LOCK_COUNT,
    parameter int unsigned c_TIMEOUT    = TIMEOUT_CNT
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_blink,
    output logic [1:0]       o_code,
    output logic             o_valid,
    output logic             o_lost,
    output logic [CNT_W-1:0] o_half_period
);

    localparam int unsigned MATCH_W = $clog2(c_LOCK_COUNT + 1);

    logic               blink_edge;
    logic [CNT_W-1:0]   r_cnt;
    state_e             r_state;
    rate_e              r_cand;
    logic [MATCH_W-1:0] r_match;

    logic               hit_c;
    rate_e              rate_c;
    logic               timeout_c;

    state_e             state_n;
    rate_e              cand_n;
    logic [MATCH_W-1:0] match_n;
    logic [1:0]         code_n;
    logic               valid_n;
    logic               lost_n;
    logic [CNT_W-1:0]   hp_n;

    sync_edge_detect u_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async   (i_blink),
        .o_edge    (blink_edge)
    );

    // Clocks since the last edge; saturates so a dead input reads as timeout.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (blink_edge) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt < CNT_W'(c_TIMEOUT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign timeout_c = (r_cnt == CNT_W'(c_TIMEOUT));

    // Window classifier on the running count, used only on an edge strobe.
    always_comb begin
        hit_c  = 1'b1;
        rate_c = RATE_100HZ;
        if (in_window(r_cnt, c_CNT_100Hz)) begin
            rate_c = RATE_100HZ;
        end else if (in_window(r_cnt, c_CNT_50Hz)) begin
            rate_c = RATE_50HZ;
        end else if (in_window(r_cnt, c_CNT_10Hz)) begin
            rate_c = RATE_10HZ;
        end else if (in_window(r_cnt, c_CNT_1Hz)) begin
            rate_c = RATE_1HZ;
        end else begin
            hit_c = 1'b0;
        end
    end

    // Next-state and output logic; an edge strobe outranks a coincident timeout.
    always_comb begin
        state_n = r_state;
        cand_n  = r_cand;
        match_n = r_match;
        code_n  = o_code;
        valid_n = o_valid;
        lost_n  = 1'b0;
        hp_n    = o_half_period;

        case (r_state)
            ST_IDLE: begin
                if (blink_edge) begin
                    state_n = ST_MEASURE;
                    match_n = '0;
                end
            end
            ST_MEASURE: begin
                if (blink_edge) begin
                    hp_n = r_cnt;
                    if (!hit_c) begin
                        match_n = '0;
                    end else if (rate_c == r_cand) begin
                        match_n = r_match + MATCH_W'(1);
                    end else begin
                        cand_n  = rate_c;
                        match_n = MATCH_W'(1);
                    end
                    if (hit_c && (match_n == MATCH_W'(c_LOCK_COUNT))) begin
                        state_n = ST_LOCKED;
                        code_n  = cand_n;
                        valid_n = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (blink_edge) begin
                    hp_n = r_cnt;
                    if (!hit_c || (rate_c != r_cand)) begin
                        state_n = ST_MEASURE;
                        valid_n = 1'b0;
                        lost_n  = 1'b1;
                        if (!hit_c) begin
                            match_n = '0;
                        end else begin
                            cand_n  = rate_c;
                            match_n = MATCH_W'(1);
                        end
                    end
                end else if (timeout_c) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                    lost_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_cand        <= RATE_100HZ;
            r_match       <= '0;
            o_code        <= 2'b00;
            o_valid       <= 1'b0;
            o_lost        <= 1'b0;
            o_half_period <= '0;
        end else begin
            r_state       <= state_n;
            r_cand        <= cand_n;
            r_match       <= match_n;
            o_code        <= code_n;
            o_valid       <= valid_n;
            o_lost        <= lost_n;
            o_half_period <= hp_n;
        end
    end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Directed bench for blink_rate_decoder: stimulus queues expected lock/loss
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_blink_rate_decoder;
    import blink_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        blink = 1'b0;
    logic [1:0]  code;
    logic        valid;
    logic        lost;
    logic [15:0] hp;

    blink_rate_decoder dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_blink       (blink),
        .o_code        (code),
        .o_valid       (valid),
        .o_lost        (lost),
        .o_half_period (hp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        valid;
        logic        lost;
        logic [1:0]  code;
        logic [15:0] hp;
        logic [31:0] cyc;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  got_ev;
    ev_t  req_ev;
    int   total    = 0;
    int   bad      = 0;
    int   last_tog = 0;
    logic prev_valid = 1'b0;

    // Monitor: every o_valid change or o_lost cycle is an event to match.
    always @(negedge clk) begin
        if ((valid !== prev_valid) || (lost !== 1'b0)) begin
            got_ev.valid = valid;
            got_ev.lost  = lost;
            got_ev.code  = code;
            got_ev.hp    = hp;
            got_ev.cyc   = 32'(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got valid=%0d lost=%0d code=%b hp=%0d cyc=%0d, required no event",
                         valid, lost, code, hp, cyc);
            end else begin
                req_ev = exp_q.pop_front();
                if (got_ev !== req_ev) begin
                    bad++;
                    $display("FAIL event: got valid=%0d lost=%0d code=%b hp=%0d cyc=%0d, required valid=%0d lost=%0d code=%b hp=%0d cyc=%0d",
                             got_ev.valid, got_ev.lost, got_ev.code, got_ev.hp, got_ev.cyc,
                             req_ev.valid, req_ev.lost, req_ev.code, req_ev.hp, req_ev.cyc);
                end
            end
        end
        prev_valid = valid;
    end

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic expect_ev(input logic v, input logic l, input logic [1:0] c, input int h, input int at);
        ev_t e;
        e.valid = v;
        e.lost  = l;
        e.code  = c;
        e.hp    = 16'(h);
        e.cyc   = 32'(at);
        exp_q.push_back(e);
    endtask

    // Toggle blink n cycles after the previous toggle; the strobe lands 3 cycles later.
    task automatic tog_after(input int n);
        repeat (n) @(negedge clk);
        blink    = ~blink;
        last_tog = cyc;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #3;
        check("reset_valid", valid, 0);
        check("reset_lost", lost, 0);
        check("reset_code", code, 0);
        check("reset_hp", hp, 0);
        @(negedge clk) rst_n = 1'b1;

        // 100 Hz: lock one cycle after the 5th strobe
        tog_after(20);
        repeat (3) tog_after(125);
        tog_after(125);
        expect_ev(1'b1, 1'b0, RATE_100HZ, 125, last_tog + 3);
        tog_after(125);

        // switch to 10 Hz: loss on first capture, relock after 3 more edges
        tog_after(1250);
        expect_ev(1'b0, 1'b1, RATE_100HZ, 1250, last_tog + 3);
        repeat (2) tog_after(1250);
        tog_after(1250);
        expect_ev(1'b1, 1'b0, RATE_10HZ, 1250, last_tog + 3);

        // 1 Hz at the lower window edge, then static input until timeout
        tog_after(10938);
        expect_ev(1'b0, 1'b1, RATE_10HZ, 10938, last_tog + 3);
        repeat (2) tog_after(10938);
        tog_after(10938);
        expect_ev(1'b1, 1'b0, RATE_1HZ, 10938, last_tog + 3);
        expect_ev(1'b0, 1'b1, RATE_1HZ, 10938, last_tog + 3 + 25000);
        repeat (25010) @(negedge clk);
        check("timeout_valid", valid, 0);
        check("timeout_code_hold", code, 3);

        // from IDLE: first edge unclassified, then 110/140 alternating locks at 100 Hz
        tog_after(20);
        tog_after(110);
        tog_after(140);
        tog_after(110);
        tog_after(140);
        expect_ev(1'b1, 1'b0, RATE_100HZ, 140, last_tog + 3);
        tog_after(141);
        expect_ev(1'b0, 1'b1, RATE_100HZ, 141, last_tog + 3);
        repeat (5) tog_after(141);
        repeat (5) @(negedge clk);
        check("no_lock_141_valid", valid, 0);
        check("no_lock_141_hp", hp, 141);

        // between classes: never locks
        repeat (6) tog_after(200);
        repeat (5) @(negedge clk);
        check("between_valid", valid, 0);
        check("between_hp", hp, 200);
        check("between_code_hold", code, 0);

        // 50 Hz lock from MEASURE, then asynchronous reset mid-lock
        repeat (3) tog_after(250);
        tog_after(250);
        expect_ev(1'b1, 1'b0, RATE_50HZ, 250, last_tog + 3);
        repeat (60) @(negedge clk);
        check("pre_reset_code", code, 1);
        @(posedge clk);
        #2;
        expect_ev(1'b0, 1'b0, RATE_100HZ, 0, cyc);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", valid, 0);
        check("async_reset_code", code, 0);
        check("async_reset_lost", lost, 0);
        check("async_reset_hp", hp, 0);
        blink = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // history discarded: relock needs 5 fresh edges
        tog_after(20);
        repeat (3) tog_after(125);
        tog_after(125);
        expect_ev(1'b1, 1'b0, RATE_100HZ, 125, last_tog + 3);
        repeat (20) @(negedge clk);

        check("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
